multicycle_control_unit: RTL and testbench

//  RV32I multicycle control FSM; successor of the single-cycle main decoder. Sequences each

---
 rtl/multicycle_control_unit.sv | 232 +++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// RV32I multicycle control FSM with memory-ready handshake and wait timeout.
// Optional ILLEGAL_TRAP_EN: illegal opcodes park the FSM in TRAP until reset.
module multicycle_control_unit #(
    parameter int OP_W    = 7,
    parameter int F_W     = 3,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] op,
    input  logic [F_W-1:0]  F,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            PCW,
    output logic            IRW,
    output logic            AdrSrc,
    output logic            MemW,
    output logic            RegW,
    output logic [1:0]      ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUOp,
    output logic [1:0]      ResultSrc,
    output logic            Jalr,
    output logic [3:0]      state_o,
    output logic            instr_done,
    output logic            bus_err
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_JAL    = 4'd9,
        S_JALR   = 4'd10,
        S_JALRWB = 4'd11,
        S_BRANCH = 4'd12,
        S_LUI    = 4'd13,
        S_TRAP   = 4'd14
    } state_e;

    localparam logic [OP_W-1:0] OP_LW   = OP_W'(7'b0000011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(7'b0100011);
    localparam logic [OP_W-1:0] OP_R    = OP_W'(7'b0110011);
    localparam logic [OP_W-1:0] OP_I    = OP_W'(7'b0010011);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(7'b1101111);
    localparam logic [OP_W-1:0] OP_JALR = OP_W'(7'b1100111);
    localparam logic [OP_W-1:0] OP_BR   = OP_W'(7'b1100011);
    localparam logic [OP_W-1:0] OP_LUI  = OP_W'(7'b0110111);

    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wait_st;
    logic               tmo;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        wait_st    = 1'b0;
        tmo        = 1'b0;
        PCW        = 1'b0;
        IRW        = 1'b0;
        AdrSrc     = 1'b0;
        MemW       = 1'b0;
        RegW       = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        ResultSrc  = 2'b00;
        Jalr       = 1'b0;
        instr_done = 1'b0;
        bus_err    = 1'b0;

        case (state_q)
            S_FETCH: begin
                wait_st   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRW       = mem_ready;
                PCW       = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALR;
                    OP_BR:        state_d = S_BRANCH;
                    OP_LUI:       state_d = S_LUI;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_d = S_TRAP;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                wait_st = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                RegW       = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                wait_st = 1'b1;
                AdrSrc  = 1'b1;
                MemW    = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegW       = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCW     = 1'b1;
                state_d = S_ALUWB;
            end
            S_JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCW       = 1'b1;
                Jalr      = 1'b1;
                state_d   = S_JALRWB;
            end
            S_JALRWB: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                Jalr    = 1'b1;
                state_d = S_ALUWB;
            end
            S_BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUOp      = 2'b01;
                PCW        = ((F == F_W'(0)) & zero) |
                             ((F == F_W'(1)) & ~zero);
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b01;
                state_d = S_ALUWB;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: state_d = S_TRAP;
`endif
            default: state_d = S_FETCH;
        endcase

        // A completing handshake on the timeout cycle is a normal finish
        tmo = wait_st && !mem_ready && (TIMEOUT != 0) && (cnt_q == TO_LAST);
        if (tmo) begin
            bus_err    = 1'b1;
            MemW       = 1'b0;
            PCW        = 1'b0;
            IRW        = 1'b0;
            RegW       = 1'b0;
            instr_done = 1'b0;
            state_d    = S_FETCH;
        end else if (wait_st && !mem_ready && state_d == state_q) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (!rst_n) begin
            PCW        = 1'b0;
            IRW        = 1'b0;
            AdrSrc     = 1'b0;
            MemW       = 1'b0;
            RegW       = 1'b0;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ALUOp      = 2'b00;
            ResultSrc  = 2'b00;
            Jalr       = 1'b0;
            instr_done = 1'b0;
            bus_err    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed literal checks plus a
// random run compared every cycle against a plan-queue reference model.
module tb_multicycle_control_unit;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst_n, zero, mem_ready;
    logic [6:0] op;
    logic [2:0] F;
    logic       PCW, IRW, AdrSrc, MemW, RegW, Jalr, instr_done, bus_err;
    logic [1:0] ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
    logic [3:0] state_o;

    int errors = 0;
    int checks = 0;

    multicycle_control_unit #(
        .OP_W(7), .F_W(3), .TIMEOUT(TIMEOUT), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .F(F), .zero(zero),
        .mem_ready(mem_ready), .PCW(PCW), .IRW(IRW), .AdrSrc(AdrSrc),
        .MemW(MemW), .RegW(RegW), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .ResultSrc(ResultSrc), .Jalr(Jalr),
        .state_o(state_o), .instr_done(instr_done), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011;
    localparam logic [6:0] RT = 7'b0110011, IT = 7'b0010011;
    localparam logic [6:0] JL = 7'b1101111, JR = 7'b1100111;
    localparam logic [6:0] BR = 7'b1100011, LU = 7'b0110111;
    localparam logic [6:0] BAD = 7'b1111111;

    // Per-state mux settings: state index -> select value
    int tA [15] = '{0, 1, 2, 0, 0, 0, 2, 2, 0, 1, 2, 1, 2, 3, 0};
    int tB [15] = '{2, 1, 1, 0, 0, 0, 0, 1, 0, 2, 1, 2, 0, 1, 0};
    int tO [15] = '{0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 1, 0, 0};
    int tR [15] = '{2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0};

    bit   chk_en = 1'b0;
    int   mstate = 0;
    int   stall  = 0;
    int   plan[$];
    bit   m_wait, m_tmo, m_adv, m_br;
    logic [19:0] m_exp, m_act;

    always @(negedge clk) begin
        if (chk_en) begin
            m_wait = (mstate == 0) || (mstate == 3) || (mstate == 5);
            m_tmo  = m_wait && !mem_ready && (TIMEOUT != 0) &&
                     (stall + 1 == TIMEOUT);
            m_adv  = !m_wait || mem_ready || m_tmo;
            m_br   = ((F == 3'd0) && zero) || ((F == 3'd1) && !zero);
            if (!rst_n) begin
                m_exp = {16'h0, 4'(mstate)} << 2;
            end else begin
                m_exp = {
                    (mstate == 0 && mem_ready) || mstate == 9 ||
                        mstate == 10 || (mstate == 12 && m_br),
                    (mstate == 0 && mem_ready),
                    (mstate == 3 || mstate == 5),
                    (mstate == 5 && !m_tmo),
                    (mstate == 4 || mstate == 8),
                    2'(tA[mstate]), 2'(tB[mstate]),
                    2'(tO[mstate]), 2'(tR[mstate]),
                    (mstate == 10 || mstate == 11),
                    4'(mstate),
                    (!m_tmo && m_adv && plan.size() == 0 &&
                        mstate != 0 && mstate != 1 && mstate != 14),
                    m_tmo
                };
            end
            m_act = {PCW, IRW, AdrSrc, MemW, RegW, ALUSrcA, ALUSrcB,
                     ALUOp, ResultSrc, Jalr, state_o, instr_done, bus_err};
            checks++;
            if (m_act !== m_exp) begin
                errors++;
                $display("FAIL outputs t=%0t st=%0d got=%05h exp=%05h",
                         $time, mstate, m_act, m_exp);
            end
            if (!rst_n || m_tmo) begin
                plan.delete();
                stall  = 0;
                mstate = 0;
            end else if (mstate == 14) begin
                mstate = 14;
            end else if (!m_adv) begin
                stall++;
            end else begin
                stall = 0;
                if (mstate == 0) begin
                    mstate = 1;
                end else begin
                    if (mstate == 1) begin
                        case (op)
                            LW: plan = {2, 3, 4};
                            SW: plan = {2, 5};
                            RT: plan = {6, 8};
                            IT: plan = {7, 8};
                            JL: plan = {9, 8};
                            JR: plan = {10, 11, 8};
                            BR: plan = {12};
                            LU: plan = {13, 8};
`ifdef ILLEGAL_TRAP_EN
                            default: plan = {14};
`else
                            default: plan.delete();
`endif
                        endcase
                    end
                    mstate = (plan.size() != 0) ? plan.pop_front() : 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [6:0] o,
                        input logic [2:0] f, input logic z, input logic m);
        @(posedge clk);
        #1;
        rst_n = r; op = o; F = f; zero = z; mem_ready = m;
        @(negedge clk);
    endtask

    int ex1 [4] = '{0, 1, 6, 8};
    int ex2 [7] = '{0, 1, 2, 3, 3, 3, 4};
    bit rd2 [7] = '{1, 1, 1, 0, 0, 1, 1};
    bit bf  [4] = '{1, 1, 0, 0};
    bit bz  [4] = '{0, 1, 1, 0};
    bit bp  [4] = '{1, 0, 1, 0};
    logic [6:0] legal [8] = '{LW, SW, RT, IT, JL, JR, BR, LU};

    initial begin
        int cnt_a, cnt_b, burst;
        rst_n = 1'b0; op = '0; F = '0; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        step(1'b0, RT, 3'd0, 1'b0, 1'b1);
        chk("rst_state", state_o, 0);
        chk("rst_irw_forced", IRW, 0);
        chk("rst_pcw_forced", PCW, 0);

        cnt_a = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, RT, 3'd0, 1'b0, 1'b1);
            chk("t1_state", state_o, ex1[i]);
            chk("t1_regw", RegW, (i == 3));
            cnt_a += int'(instr_done);
        end
        chk("t1_done_once", cnt_a, 1);

        for (int i = 0; i < 7; i++) begin
            step(1'b1, LW, 3'd0, 1'b0, rd2[i]);
            chk("t2_state", state_o, ex2[i]);
            chk("t2_regw", RegW, (i == 6));
        end

        step(1'b1, SW, 3'd0, 1'b0, 1'b1);
        chk("t3_fetch", state_o, 0);
        step(1'b1, SW, 3'd0, 1'b0, 1'b0);
        step(1'b1, SW, 3'd0, 1'b0, 1'b0);
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b1, SW, 3'd0, 1'b0, 1'b0);
            chk("t3_state", state_o, 5);
            chk("t3_berr_last", bus_err, (i == 14));
            cnt_a += int'(MemW);
            cnt_b += int'(bus_err);
        end
        chk("t3_memw_cycles", cnt_a, 14);
        chk("t3_berr_count", cnt_b, 1);

        for (int k = 0; k < 4; k++) begin
            step(1'b1, BR, 3'(bf[k]), bz[k], 1'b1);
            chk("t4_fetch", state_o, 0);
            step(1'b1, BR, 3'(bf[k]), bz[k], 1'b1);
            step(1'b1, BR, 3'(bf[k]), bz[k], 1'b1);
            chk("t4_state", state_o, 12);
            chk("t4_pcw", PCW, bp[k]);
            chk("t4_done", instr_done, 1);
        end

        step(1'b1, BAD, 3'd0, 1'b0, 1'b1);
        chk("t5_fetch", state_o, 0);
        step(1'b1, BAD, 3'd0, 1'b0, 1'b1);
        chk("t5_decode", state_o, 1);
        step(1'b1, BAD, 3'd0, 1'b0, 1'b1);
`ifdef ILLEGAL_TRAP_EN
        chk("t5_trap", state_o, 14);
        step(1'b1, BAD, 3'd0, 1'b0, 1'b1);
        chk("t5_trap_hold", state_o, 14);
        chk("t5_trap_quiet", {PCW, IRW, RegW, MemW}, 0);
`else
        chk("t5_nop_fetch", state_o, 0);
        step(1'b1, BAD, 3'd0, 1'b0, 1'b1);
        chk("t5_nop_decode", state_o, 1);
`endif
        step(1'b0, SW, 3'd0, 1'b0, 1'b1);

        step(1'b1, SW, 3'd0, 1'b0, 1'b1);
        chk("t6_fetch", state_o, 0);
        step(1'b1, SW, 3'd0, 1'b0, 1'b1);
        step(1'b1, SW, 3'd0, 1'b0, 1'b1);
        step(1'b1, SW, 3'd0, 1'b0, 1'b0);
        chk("t6_memw_on", MemW, 1);
        step(1'b0, SW, 3'd0, 1'b0, 1'b0);
        chk("t6_memw_rst", MemW, 0);
        chk("t6_berr_rst", bus_err, 0);
        step(1'b1, SW, 3'd0, 1'b0, 1'b1);
        chk("t6_after", state_o, 0);

        burst = 0;
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            #1;
            rst_n = ($urandom_range(0, 150) != 0);
            zero  = 1'($urandom_range(0, 1));
            if (mstate == 0) begin
                op = ($urandom_range(0, 14) == 0) ? 7'($urandom())
                                                  : legal[$urandom_range(0, 7)];
                F  = 3'($urandom_range(0, 3));
            end
            if (burst > 0) begin
                mem_ready = 1'b0;
                burst--;
            end else if ($urandom_range(0, 60) == 0) begin
                burst = $urandom_range(10, 20);
                mem_ready = 1'b0;
            end else begin
                mem_ready = ($urandom_range(0, 3) != 0);
            end
        end
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
